// File: rtl/uart_report_sched.sv
// Round-robin report scheduler for the shared byte UART.
// Sends "<tag>MM:SS\r\n" for stopwatch or alarm whenever a value or mode changes.
module uart_report_sched #(
  parameter logic [7:0] TAG_S = 8'h53,
  parameter logic [7:0] TAG_A = 8'h41
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] st,
  input  logic [5:0] sw_mm,
  input  logic [5:0] sw_ss,
  input  logic [5:0] al_mm,
  input  logic [5:0] al_ss,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       frame_active,
  output logic       grant_src
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_HI, WAIT_LO, DONE
  } state_t;

  localparam logic [11:0] NONE = 12'hFFF;

  state_t      state, state_nxt;
  logic [1:0]  st_q;
  logic [11:0] last_s, last_a, snap;
  logic        last_grant;
  logic [2:0]  idx;
  logic        pend_s, pend_a, grant, pick;
  logic [1:0]  newly;
  logic [7:0]  byte_cur;
  logic        start_nxt;

  function automatic logic [7:0] tens(input logic [5:0] v);
    logic [5:0] q;
    q = v / 6'd10;
    return 8'h30 + {2'b00, q};
  endfunction

  function automatic logic [7:0] ones(input logic [5:0] v);
    logic [5:0] r;
    r = v % 6'd10;
    return 8'h30 + {2'b00, r};
  endfunction

  assign pend_s = st[0] & ({sw_mm, sw_ss} != last_s);
  assign pend_a = st[1] & ({al_mm, al_ss} != last_a);
  assign grant  = pend_s | pend_a;
  assign pick   = (pend_s & pend_a) ? ~last_grant : pend_a;
  assign newly  = st & ~st_q;

  always_comb begin
    byte_cur = 8'h00;
    case (idx)
      3'd0: byte_cur = grant_src ? TAG_A : TAG_S;
      3'd1: byte_cur = tens(snap[11:6]);
      3'd2: byte_cur = ones(snap[11:6]);
      3'd3: byte_cur = 8'h3A;
      3'd4: byte_cur = tens(snap[5:0]);
      3'd5: byte_cur = ones(snap[5:0]);
      3'd6: byte_cur = 8'h0D;
      default: byte_cur = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)    state_nxt = LOAD;
      LOAD:    if (!tx_busy) state_nxt = WAIT_HI;
      WAIT_HI: if (tx_busy)  state_nxt = WAIT_LO;
      WAIT_LO: if (!tx_busy)
                 state_nxt = (idx == 3'd7) ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_nxt = (state == LOAD) & ~tx_busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      frame_active <= 1'b0;
      grant_src    <= 1'b0;
      last_grant   <= 1'b1;
      last_s       <= NONE;
      last_a       <= NONE;
      snap         <= 12'h000;
      idx          <= 3'd0;
      st_q         <= 2'b00;
    end else begin
      tx_start <= start_nxt;
      st_q     <= st;
      if (state == LOAD) tx_data <= byte_cur;
      case (state)
        IDLE: if (grant) begin
          snap         <= pick ? {al_mm, al_ss} : {sw_mm, sw_ss};
          grant_src    <= pick;
          last_grant   <= pick;
          frame_active <= 1'b1;
          idx          <= 3'd0;
        end
        WAIT_LO: if (!tx_busy && idx != 3'd7) idx <= idx + 3'd1;
        DONE: begin
          frame_active <= 1'b0;
          if (grant_src) last_a <= snap;
          else           last_s <= snap;
        end
        default: ;
      endcase
      // a newly enabled source must report even if its value is unchanged
      if (newly[0]) last_s <= NONE;
      if (newly[1]) last_a <= NONE;
    end
  end

endmodule
